// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through data-cache controller behind the LSQ
//
// Direct-mapped cache with 8-byte lines. Stores are write-through and do not
// allocate a line. A store that hits a line updates that line's data.
// Load hits are answered combinationally with tag 0. Load misses and all
// stores go to the memory bus. Fill data returns to the LSQ under the memory
// transaction tag.
//
// Optional feature: define DCACHE_STATS_EN to add the hit_count/miss_count outputs.
//
// Ports:
//   clk, reset              clock; asynchronous active-low reset
//   lsq2mem_command/addr/data   head-of-queue command from the LSQ
//   mem2lsq_response        tag accepted by memory for a forwarded load miss (0 = none)
//   dcache2lsq_valid/tag/data   load data to the LSQ (tag 0 = same-cycle hit)
//   dcache2lsq_st_received  a store was seen this cycle; dcache2lsq_tag carries its ack tag
//   proc2mem_command/addr/data  command to memory (address is 8-byte aligned)
//   mem2proc_response       memory accept tag for this cycle's command (0 = busy)
//   mem2proc_data/tag       returning fill data and its tag (tag 0 = no return)
//   hit_count, miss_count   accepted load hit/miss counters (DCACHE_STATS_EN only)
module dcache_ctrl #(
   parameter int DC_IDX = 5,
   parameter int TAG_W  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        lsq2mem_command,
   input  logic [63:0]       lsq2mem_addr,
   input  logic [63:0]       lsq2mem_data,
   output logic [TAG_W-1:0]  mem2lsq_response,
   output logic              dcache2lsq_valid,
   output logic [TAG_W-1:0]  dcache2lsq_tag,
   output logic [63:0]       dcache2lsq_data,
   output logic              dcache2lsq_st_received,
   output logic [1:0]        proc2mem_command,
   output logic [63:0]       proc2mem_addr,
   output logic [63:0]       proc2mem_data,
   input  logic [TAG_W-1:0]  mem2proc_response,
   input  logic [63:0]       mem2proc_data,
   input  logic [TAG_W-1:0]  mem2proc_tag
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);

   localparam int LINES  = 1 << DC_IDX;
   localparam int LTAG_W = 64 - 3 - DC_IDX;
   localparam int NMSHR  = 1 << TAG_W;

   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;

   // Cache line state
   logic [LINES-1:0]  valid_q, valid_d;
   logic [LTAG_W-1:0] ltag_q  [LINES];
   logic [63:0]       ldata_q [LINES];

   // MSHRs, indexed directly by memory tag. Entry 0 is never allocated.
   logic [NMSHR-1:0]  busy_q, busy_d;
   logic [NMSHR-1:0]  fill_ok_q, fill_ok_d;
   logic [DC_IDX-1:0] m_idx_q [NMSHR];
   logic [LTAG_W-1:0] m_tag_q [NMSHR];

   logic [DC_IDX-1:0] req_idx;
   logic [LTAG_W-1:0] req_tag;
   logic              unused_addr_bits;
   logic              is_load, is_store, hit;
   logic              fill_en, ld_hit, alloc_en, st_acc, st_upd;

   assign req_idx          = lsq2mem_addr[DC_IDX+2:3];
   assign req_tag          = lsq2mem_addr[63:DC_IDX+3];
   assign unused_addr_bits = ^lsq2mem_addr[2:0];

   // All events are gated by reset so that nothing is seen while reset is held.
   assign is_load  = reset && (lsq2mem_command == BUS_LOAD);
   assign is_store = reset && (lsq2mem_command == BUS_STORE);
   assign hit      = valid_q[req_idx] && (ltag_q[req_idx] == req_tag);

   // A return for a non-busy tag (including tag 0) is ignored. A valid return
   // owns the cycle, and no LSQ command is forwarded to memory in that cycle.
   assign fill_en  = reset && busy_q[mem2proc_tag];
   assign ld_hit   = is_load && !fill_en && hit;
   assign alloc_en = is_load && !fill_en && !hit && (mem2proc_response != '0);
   assign st_acc   = is_store && !fill_en && (mem2proc_response != '0);
   assign st_upd   = st_acc && hit;

   always_comb begin
      valid_d   = valid_q;
      busy_d    = busy_q;
      fill_ok_d = fill_ok_q;
      if (fill_en) begin
         busy_d[mem2proc_tag] = 1'b0;
         if (fill_ok_q[mem2proc_tag])
            valid_d[m_idx_q[mem2proc_tag]] = 1'b1;
      end
      if (alloc_en) begin
         busy_d[mem2proc_response]    = 1'b1;
         fill_ok_d[mem2proc_response] = 1'b1;
      end
      // An outstanding fill for a line just written by an accepted store would
      // bring back stale data, so that fill is not installed in the cache.
      if (st_acc) begin
         for (int i = 0; i < NMSHR; i++) begin
            if (busy_q[i] && (m_idx_q[i] == req_idx) && (m_tag_q[i] == req_tag))
               fill_ok_d[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q   <= '0;
         busy_q    <= '0;
         fill_ok_q <= '0;
      end else begin
         valid_q   <= valid_d;
         busy_q    <= busy_d;
         fill_ok_q <= fill_ok_d;
      end
   end

   // Payload arrays have no reset; the valid and busy bits qualify them.
   always_ff @(posedge clk) begin
      if (fill_en && fill_ok_q[mem2proc_tag]) begin
         ltag_q[m_idx_q[mem2proc_tag]]  <= m_tag_q[mem2proc_tag];
         ldata_q[m_idx_q[mem2proc_tag]] <= mem2proc_data;
      end else if (st_upd) begin
         ldata_q[req_idx] <= lsq2mem_data;
      end
      if (alloc_en) begin
         m_idx_q[mem2proc_response] <= req_idx;
         m_tag_q[mem2proc_response] <= req_tag;
      end
   end

   always_comb begin
      mem2lsq_response       = '0;
      dcache2lsq_valid       = 1'b0;
      dcache2lsq_tag         = '0;
      dcache2lsq_data        = '0;
      dcache2lsq_st_received = is_store;
      proc2mem_command       = BUS_NONE;
      proc2mem_addr          = {lsq2mem_addr[63:3], 3'b000};
      proc2mem_data          = lsq2mem_data;
      if (fill_en) begin
         // A store seen in this cycle is told to retry, because it was not
         // forwarded. The LSQ separates the fill from the store ack by
         // dcache2lsq_valid.
         dcache2lsq_valid = 1'b1;
         dcache2lsq_tag   = mem2proc_tag;
         dcache2lsq_data  = mem2proc_data;
      end else if (is_load) begin
         if (hit) begin
            dcache2lsq_valid = 1'b1;
            dcache2lsq_data  = ldata_q[req_idx];
         end else begin
            proc2mem_command = BUS_LOAD;
            mem2lsq_response = mem2proc_response;
         end
      end else if (is_store) begin
         proc2mem_command = BUS_STORE;
         dcache2lsq_tag   = mem2proc_response;
      end
   end

`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q, miss_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         if (ld_hit && (hit_cnt_q != 32'hFFFF_FFFF))
            hit_cnt_q <= hit_cnt_q + 32'd1;
         if (alloc_en && (miss_cnt_q != 32'hFFFF_FFFF))
            miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`else
   logic unused_ld_hit;
   assign unused_ld_hit = ld_hit;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - directed self-checking bench for dcache_ctrl
module tb_dcache_ctrl;

   localparam int TAG_W = 4;
   localparam logic [1:0] NONE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] STORE = 2'd2;

   logic              clk = 1'b0;
   logic              reset;
   logic [1:0]        lsq2mem_command;
   logic [63:0]       lsq2mem_addr;
   logic [63:0]       lsq2mem_data;
   logic [TAG_W-1:0]  mem2lsq_response;
   logic              dcache2lsq_valid;
   logic [TAG_W-1:0]  dcache2lsq_tag;
   logic [63:0]       dcache2lsq_data;
   logic              dcache2lsq_st_received;
   logic [1:0]        proc2mem_command;
   logic [63:0]       proc2mem_addr;
   logic [63:0]       proc2mem_data;
   logic [TAG_W-1:0]  mem2proc_response;
   logic [63:0]       mem2proc_data;
   logic [TAG_W-1:0]  mem2proc_tag;
`ifdef DCACHE_STATS_EN
   logic [31:0]       hit_count;
   logic [31:0]       miss_count;
`endif

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   dcache_ctrl #(.DC_IDX(5), .TAG_W(TAG_W)) dut (
      .clk                    (clk),
      .reset                  (reset),
      .lsq2mem_command        (lsq2mem_command),
      .lsq2mem_addr           (lsq2mem_addr),
      .lsq2mem_data           (lsq2mem_data),
      .mem2lsq_response       (mem2lsq_response),
      .dcache2lsq_valid       (dcache2lsq_valid),
      .dcache2lsq_tag         (dcache2lsq_tag),
      .dcache2lsq_data        (dcache2lsq_data),
      .dcache2lsq_st_received (dcache2lsq_st_received),
      .proc2mem_command       (proc2mem_command),
      .proc2mem_addr          (proc2mem_addr),
      .proc2mem_data          (proc2mem_data),
      .mem2proc_response      (mem2proc_response),
      .mem2proc_data          (mem2proc_data),
      .mem2proc_tag           (mem2proc_tag)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count              (hit_count),
      .miss_count             (miss_count)
`endif
   );

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and let them settle for checking.
   task automatic cyc(input logic [1:0] cmd, input logic [63:0] addr, input logic [63:0] data,
                      input logic [3:0] resp, input logic [3:0] rtag, input logic [63:0] rdata);
      @(negedge clk);
      lsq2mem_command   = cmd;
      lsq2mem_addr      = addr;
      lsq2mem_data      = data;
      mem2proc_response = resp;
      mem2proc_tag      = rtag;
      mem2proc_data     = rdata;
      #1;
   endtask

   initial begin
      reset = 1'b0;
      lsq2mem_command = NONE; lsq2mem_addr = '0; lsq2mem_data = '0;
      mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;

      // Outputs are quiet while reset is held, even with a store presented.
      cyc(STORE, 64'h100, 64'h1, 4'd2, 4'd0, 64'h0);
      chk("rst_cmd",   proc2mem_command, NONE);
      chk("rst_st",    dcache2lsq_st_received, 1'b0);
      chk("rst_valid", dcache2lsq_valid, 1'b0);
      chk("rst_tag",   dcache2lsq_tag, 4'd0);
      chk("rst_resp",  mem2lsq_response, 4'd0);
      cyc(NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
      reset = 1'b1;

      // Load miss at an unaligned address, accepted as tag 3.
      cyc(LOAD, 64'h105, 64'h0, 4'd3, 4'd0, 64'h0);
      chk("miss_valid", dcache2lsq_valid, 1'b0);
      chk("miss_cmd",   proc2mem_command, LOAD);
      chk("miss_addr",  proc2mem_addr, 64'h100);
      chk("miss_resp",  mem2lsq_response, 4'd3);
      cyc(NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
      chk("idle_valid", dcache2lsq_valid, 1'b0);
      chk("idle_cmd",   proc2mem_command, NONE);
      cyc(NONE, 64'h0, 64'h0, 4'd0, 4'd3, 64'hDEAD);
      chk("fill_valid", dcache2lsq_valid, 1'b1);
      chk("fill_tag",   dcache2lsq_tag, 4'd3);
      chk("fill_data",  dcache2lsq_data, 64'hDEAD);
      cyc(LOAD, 64'h100, 64'h0, 4'd0, 4'd0, 64'h0);
      chk("hit_valid", dcache2lsq_valid, 1'b1);
      chk("hit_tag",   dcache2lsq_tag, 4'd0);
      chk("hit_data",  dcache2lsq_data, 64'hDEAD);
      chk("hit_cmd",   proc2mem_command, NONE);

      // Rejected miss allocates nothing; stray returns are ignored.
      cyc(LOAD, 64'h200, 64'h0, 4'd0, 4'd0, 64'h0);
      chk("rej_cmd",  proc2mem_command, LOAD);
      chk("rej_resp", mem2lsq_response, 4'd0);
      cyc(NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'hBAD);
      chk("ret0_valid", dcache2lsq_valid, 1'b0);
      cyc(NONE, 64'h0, 64'h0, 4'd0, 4'd7, 64'hBAD);
      chk("ret7_valid", dcache2lsq_valid, 1'b0);
      cyc(NONE, 64'h0, 64'h0, 4'd0, 4'd3, 64'hBAD);
      chk("ret3_again", dcache2lsq_valid, 1'b0);

      // Store hit writes through and updates the line.
      cyc(STORE, 64'h100, 64'h55, 4'd2, 4'd0, 64'h0);
      chk("st_recv",  dcache2lsq_st_received, 1'b1);
      chk("st_tag",   dcache2lsq_tag, 4'd2);
      chk("st_cmd",   proc2mem_command, STORE);
      chk("st_data",  proc2mem_data, 64'h55);
      chk("st_valid", dcache2lsq_valid, 1'b0);
      cyc(LOAD, 64'h100, 64'h0, 4'd0, 4'd0, 64'h0);
      chk("sthit_valid", dcache2lsq_valid, 1'b1);
      chk("sthit_data",  dcache2lsq_data, 64'h55);

      // A store to a line with an outstanding miss suppresses that fill.
      cyc(LOAD, 64'h300, 64'h0, 4'd4, 4'd0, 64'h0);
      chk("m300_resp", mem2lsq_response, 4'd4);
      cyc(STORE, 64'h300, 64'h77, 4'd5, 4'd0, 64'h0);
      chk("st300_tag", dcache2lsq_tag, 4'd5);
      cyc(NONE, 64'h0, 64'h0, 4'd0, 4'd4, 64'h11);
      chk("sup_valid", dcache2lsq_valid, 1'b1);
      chk("sup_tag",   dcache2lsq_tag, 4'd4);
      chk("sup_data",  dcache2lsq_data, 64'h11);
      cyc(LOAD, 64'h300, 64'h0, 4'd0, 4'd0, 64'h0);
      chk("sup_miss", dcache2lsq_valid, 1'b0);
      chk("sup_cmd",  proc2mem_command, LOAD);
      cyc(LOAD, 64'h100, 64'h0, 4'd0, 4'd0, 64'h0);
      chk("keep_data", dcache2lsq_data, 64'h55);

      // A fill into an occupied line replaces it.
      cyc(LOAD, 64'h200, 64'h0, 4'd6, 4'd0, 64'h0);
      cyc(NONE, 64'h0, 64'h0, 4'd0, 4'd6, 64'h22);
      cyc(LOAD, 64'h200, 64'h0, 4'd0, 4'd0, 64'h0);
      chk("repl_valid", dcache2lsq_valid, 1'b1);
      chk("repl_data",  dcache2lsq_data, 64'h22);
      cyc(LOAD, 64'h100, 64'h0, 4'd0, 4'd0, 64'h0);
      chk("evict_miss", dcache2lsq_valid, 1'b0);

      // A store during a fill cycle is not forwarded.
      cyc(LOAD, 64'h300, 64'h0, 4'd7, 4'd0, 64'h0);
      cyc(STORE, 64'h400, 64'h99, 4'd8, 4'd7, 64'h33);
      chk("fst_recv",  dcache2lsq_st_received, 1'b1);
      chk("fst_tag",   dcache2lsq_tag, 4'd7);
      chk("fst_valid", dcache2lsq_valid, 1'b1);
      chk("fst_data",  dcache2lsq_data, 64'h33);
      chk("fst_cmd",   proc2mem_command, NONE);
      cyc(LOAD, 64'h300, 64'h0, 4'd0, 4'd0, 64'h0);
      chk("fst_hit", dcache2lsq_data, 64'h33);

      // A load during a fill cycle is neither forwarded nor allocated.
      cyc(LOAD, 64'h500, 64'h0, 4'd9, 4'd0, 64'h0);
      cyc(LOAD, 64'h600, 64'h0, 4'd10, 4'd9, 64'h44);
      chk("fld_resp",  mem2lsq_response, 4'd0);
      chk("fld_cmd",   proc2mem_command, NONE);
      chk("fld_tag",   dcache2lsq_tag, 4'd9);
      chk("fld_data",  dcache2lsq_data, 64'h44);
      cyc(NONE, 64'h0, 64'h0, 4'd0, 4'd10, 64'hBAD);
      chk("fld_noalloc", dcache2lsq_valid, 1'b0);

      // Reset drops both outstanding misses and valid lines.
      cyc(LOAD, 64'h700, 64'h0, 4'd5, 4'd0, 64'h0);
      chk("r5_resp", mem2lsq_response, 4'd5);
      @(negedge clk);
      lsq2mem_command = NONE;
      reset = 1'b0;
      #1;
      chk("rst2_cmd", proc2mem_command, NONE);
      @(negedge clk);
      reset = 1'b1;
      cyc(NONE, 64'h0, 64'h0, 4'd0, 4'd5, 64'hBAD);
      chk("r5_drop", dcache2lsq_valid, 1'b0);
      cyc(LOAD, 64'h500, 64'h0, 4'd0, 4'd0, 64'h0);
      chk("rst_inval", dcache2lsq_valid, 1'b0);

`ifdef DCACHE_STATS_EN
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("cnt_hit0",  hit_count, 32'd0);
      chk("cnt_miss0", miss_count, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      cyc(LOAD, 64'h100, 64'h0, 4'd1, 4'd0, 64'h0);
      cyc(NONE, 64'h0, 64'h0, 4'd0, 4'd1, 64'hAB);
      cyc(LOAD, 64'h100, 64'h0, 4'd0, 4'd0, 64'h0);
      cyc(NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
      chk("cnt_hit1",  hit_count, 32'd1);
      chk("cnt_miss1", miss_count, 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
